// File: rtl/s832_response_capture_pkg.sv
// Shared definitions for the s832 response capture stage: response width,
// FSM encoding and the bit position of every G-net inside RESP_IN.
package s832_cap_pkg;

   localparam int OUT_W = 19;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } state_t;

   // RESP_IN bit index of each s832 primary output
   localparam int G43  = 0;
   localparam int G45  = 1;
   localparam int G47  = 2;
   localparam int G49  = 3;
   localparam int G53  = 4;
   localparam int G55  = 5;
   localparam int G288 = 6;
   localparam int G290 = 7;
   localparam int G292 = 8;
   localparam int G296 = 9;
   localparam int G298 = 10;
   localparam int G300 = 11;
   localparam int G302 = 12;
   localparam int G310 = 13;
   localparam int G312 = 14;
   localparam int G315 = 15;
   localparam int G322 = 16;
   localparam int G325 = 17;
   localparam int G327 = 18;

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/s832_response_capture_if.sv
// Event readout port of the capture stage: show-ahead head, occupancy and
// sticky overflow flag, drained with a valid/ready handshake.
interface s832_response_capture_if #(
   parameter int DW = 31,
   parameter int CW = 4
);
   logic          EVT_VALID;
   logic          EVT_READY;
   logic [DW-1:0] EVT_DATA;
   logic [CW-1:0] EVT_COUNT;
   logic          OVF;

   modport master (output EVT_VALID, EVT_DATA, EVT_COUNT, OVF, input EVT_READY);
   modport slave  (input EVT_VALID, EVT_DATA, EVT_COUNT, OVF, output EVT_READY);
endinterface

// File: rtl/s832_response_capture_fifo.sv
// Synchronous show-ahead FIFO. The head word is held in a register so the
// output is glitch-free and reads as zero whenever the FIFO is empty.
module cap_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 31
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       valid,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr, rd_nxt;
   logic [CW-1:0]    cnt_nxt;
   logic [WIDTH-1:0] head_nxt;
   logic             do_push, do_pop;

   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && valid;
   // a full FIFO still accepts a push when the head leaves in the same cycle
   assign do_push = push && (!full || do_pop);

   always_comb begin
      rd_nxt   = do_pop ? rd_ptr + 1'b1 : rd_ptr;
      cnt_nxt  = count + CW'(do_push) - CW'(do_pop);
      head_nxt = (do_push && wr_ptr == rd_nxt) ? din : mem[rd_nxt];
      if (cnt_nxt == '0)
         head_nxt = '0;
   end

   always_ff @(posedge clk)
      if (do_push && !clr)
         mem[wr_ptr] <= din;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
         valid  <= 1'b0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
         valid  <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + AW'(do_push);
         rd_ptr <= rd_nxt;
         count  <= cnt_nxt;
         dout   <= head_nxt;
         valid  <= (cnt_nxt != '0);
      end
   end

endmodule

// File: rtl/s832_response_capture.sv
// Samples the s832 outputs each cycle, turns every change into a
// {timestamp, sample} event and queues it for the readout port.
module s832_response_capture
   import s832_cap_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int TS_W  = 12
) (
   input  logic                CK,
   input  logic                RN,
   input  logic                EN,
   input  logic                CLR,
   input  logic [OUT_W-1:0]    RESP_IN,
   s832_response_capture_if.master evt
);
   localparam int DW = TS_W + OUT_W;

   state_t           state;
   logic [OUT_W-1:0] samp, prev;
   logic [TS_W-1:0]  ts;
   logic             ovf;
   logic             push_req, full;
   logic [DW-1:0]    push_data;

   // PRIME always records a baseline; RUN records only real changes
   always_comb begin
      push_req  = 1'b0;
      push_data = '0;
      if (!CLR) begin
         case (state)
            PRIME: begin
               push_req  = 1'b1;
               push_data = {{TS_W{1'b0}}, samp};
            end
            RUN: begin
               push_req  = EN && (samp != prev);
               push_data = {ts, samp};
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         state <= IDLE;
         samp  <= '0;
         prev  <= '0;
         ts    <= '0;
         ovf   <= 1'b0;
      end else begin
         samp <= RESP_IN;
         if (CLR) begin
            state <= IDLE;
            ovf   <= 1'b0;
         end else begin
            if (push_req && full && !(evt.EVT_VALID && evt.EVT_READY))
               ovf <= 1'b1;
            case (state)
               IDLE:
                  if (EN) state <= PRIME;
               PRIME: begin
                  ts    <= '0;
                  prev  <= samp;
                  state <= RUN;
               end
               RUN:
                  if (!EN) begin
                     state <= IDLE;
                  end else begin
                     ts   <= ts + 1'b1;
                     prev <= samp;
                  end
               default:
                  state <= IDLE;
            endcase
         end
      end
   end

   assign evt.OVF = ovf;

   cap_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DW)
   ) u_fifo (
      .clk   (CK),
      .rst_n (RN),
      .clr   (CLR),
      .push  (push_req),
      .pop   (evt.EVT_READY),
      .din   (push_data),
      .dout  (evt.EVT_DATA),
      .valid (evt.EVT_VALID),
      .full  (full),
      .count (evt.EVT_COUNT)
   );

endmodule

// File: tb/tb_s832_response_capture.sv
// Directed bench for the s832 response capture stage: a per-cycle vector
// table for baseline/latency/handshake, then hand sequences for full/reset/clear.
module tb_s832_response_capture;
   import s832_cap_pkg::*;

   localparam int DEPTH = 8;
   localparam int TS_W  = 12;
   localparam int DW    = TS_W + OUT_W;
   localparam int CW    = 4;

   logic             CK = 1'b0;
   logic             RN, EN, CLR;
   logic [OUT_W-1:0] RESP_IN;

   s832_response_capture_if #(.DW(DW), .CW(CW)) evt_bus ();

   s832_response_capture #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
      .CK      (CK),
      .RN      (RN),
      .EN      (EN),
      .CLR     (CLR),
      .RESP_IN (RESP_IN),
      .evt     (evt_bus.master)
   );

   always #5 CK = ~CK;

   typedef struct {
      logic             en, clr, rdy;
      logic [OUT_W-1:0] resp;
      logic             v;
      logic [DW-1:0]    d;
      logic [CW-1:0]    c;
      logic             o;
   } vec_t;

   vec_t tbl [24];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(input logic en, clr, rdy, input logic [OUT_W-1:0] resp,
                               input logic v, input logic [DW-1:0] d,
                               input logic [CW-1:0] c, input logic o);
      vec_t r;
      r.en = en; r.clr = clr; r.rdy = rdy; r.resp = resp;
      r.v = v; r.d = d; r.c = c; r.o = o;
      return r;
   endfunction

   function automatic logic [DW-1:0] ev(input int t, input logic [OUT_W-1:0] s);
      logic [TS_W-1:0] tt;
      tt = TS_W'(t);
      return {tt, s};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic v, input logic [DW-1:0] d,
                          input logic [CW-1:0] c, input logic o);
      chk({tag, ".valid"}, 64'(evt_bus.EVT_VALID), 64'(v));
      chk({tag, ".data"},  64'(evt_bus.EVT_DATA),  64'(d));
      chk({tag, ".count"}, 64'(evt_bus.EVT_COUNT), 64'(c));
      chk({tag, ".ovf"},   64'(evt_bus.OVF),       64'(o));
   endtask

   task automatic step();
      @(posedge CK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [DW-1:0] e [8];

      // baseline, latency and hold-while-not-ready vectors
      tbl[0] = mk(1, 0, 0, 19'h0, 0, '0, 0, 0);
      for (int i = 1; i <= 10; i++) tbl[i] = mk(1, 0, 0, 19'h0, 1, ev(0, 19'h0), 1, 0);
      tbl[11] = mk(1, 0, 1, 19'h0, 0, '0, 0, 0);
      tbl[12] = mk(1, 1, 0, 19'h0, 0, '0, 0, 0);
      tbl[13] = mk(1, 0, 0, 19'h0, 0, '0, 0, 0);
      tbl[14] = mk(1, 0, 0, 19'h0, 1, ev(0, 19'h0), 1, 0);
      tbl[15] = mk(1, 0, 1, 19'h0, 0, '0, 0, 0);
      for (int i = 16; i <= 18; i++) tbl[i] = mk(1, 0, 0, 19'h0, 0, '0, 0, 0);
      tbl[19] = mk(1, 0, 0, 19'h1, 0, '0, 0, 0);
      for (int i = 20; i <= 22; i++) tbl[i] = mk(1, 0, 0, 19'h1, 1, ev(5, 19'h1), 1, 0);
      tbl[23] = mk(1, 0, 1, 19'h1, 0, '0, 0, 0);

      RN = 1'b0; EN = 1'b0; CLR = 1'b0; RESP_IN = '0; evt_bus.EVT_READY = 1'b0;
      #12;
      chk_all("reset", 0, '0, 0, 0);
      @(negedge CK);
      RN = 1'b1;
      @(posedge CK); #1;

      for (int i = 0; i < 24; i++) begin
         EN = tbl[i].en; CLR = tbl[i].clr; evt_bus.EVT_READY = tbl[i].rdy;
         RESP_IN = tbl[i].resp;
         step();
         chk_all($sformatf("vec%0d", i), tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].o);
      end

      // fill past capacity with READY low; TS is 9 entering this loop
      CLR = 1'b0; EN = 1'b1; evt_bus.EVT_READY = 1'b0;
      for (int i = 0; i < 12; i++) begin
         RESP_IN = (i % 2 == 1) ? 19'h1 : 19'h0;
         step();
         chk($sformatf("fill%0d.count", i), 64'(evt_bus.EVT_COUNT), 64'((i > 8) ? 8 : i));
         chk($sformatf("fill%0d.ovf", i), 64'(evt_bus.OVF), 64'(i >= 9));
      end
      chk("full.head", 64'(evt_bus.EVT_DATA), 64'(ev(10, 19'h0)));

      // full FIFO: pop and push land in the same cycle
      RESP_IN = 19'h1; evt_bus.EVT_READY = 1'b1;
      step();
      chk_all("fullpp", 1, ev(11, 19'h1), 8, 1);

      for (int j = 0; j < 7; j++) e[j] = ev(11 + j, OUT_W'((1 + j) % 2));
      e[7] = ev(21, 19'h1);
      EN = 1'b0;
      for (int j = 1; j < 8; j++) begin
         step();
         chk($sformatf("drain%0d.data", j), 64'(evt_bus.EVT_DATA), 64'(e[j]));
         chk($sformatf("drain%0d.count", j), 64'(evt_bus.EVT_COUNT), 64'(8 - j));
      end
      step();
      chk_all("drained", 0, '0, 0, 1);

      // three entries queued, then async reset mid-cycle
      EN = 1'b1; evt_bus.EVT_READY = 1'b0; RESP_IN = 19'h1;
      step(); step();
      RESP_IN = 19'h0; step();
      RESP_IN = 19'h1; step(); step();
      chk_all("pre_rst", 1, ev(0, 19'h1), 3, 1);
      #2 RN = 1'b0;
      #1 chk_all("async_rst", 0, '0, 0, 0);
      @(negedge CK);
      RN = 1'b1;
      RESP_IN = 19'h1 << G327;
      step(); step();
      chk_all("rebase", 1, ev(0, 19'h40000), 1, 0);

      // overflow again, drain to 5, then flush
      for (int i = 0; i < 12; i++) begin
         RESP_IN = (i % 2 == 1) ? 19'h40000 : 19'h0;
         step();
      end
      chk("ovf2.count", 64'(evt_bus.EVT_COUNT), 64'(8));
      chk("ovf2.ovf", 64'(evt_bus.OVF), 64'(1));
      EN = 1'b0; evt_bus.EVT_READY = 1'b1;
      step(); step(); step();
      chk("pre_clr.count", 64'(evt_bus.EVT_COUNT), 64'(5));
      chk("pre_clr.ovf", 64'(evt_bus.OVF), 64'(1));
      evt_bus.EVT_READY = 1'b0; CLR = 1'b1;
      step();
      chk_all("clr", 0, '0, 0, 0);
      CLR = 1'b0;
      step();
      chk_all("clr_idle", 0, '0, 0, 0);
      EN = 1'b1; RESP_IN = 19'h3;
      step(); step();
      chk_all("post_clr", 1, ev(0, 19'h3), 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
